rr_arb_fifo: RTL and testbench

RR_ARB_FIFO -- requirements
Module: rr_arb_fifo

---
 rtl/rr_arb_fifo.sv | 169 ++++++++++++++++
 tb/tb_rr_arb_fifo.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_fifo.sv
// Round-robin arbiter whose grants are queued, by requester index, into a grant FIFO.
// Also watches for requesters that wait too long and for requests withdrawn before their grant.
module rr_arb_fifo #(
    parameter int N       = 4,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16,
    localparam int IW     = $clog2(N),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  arb_req,
    output logic [N-1:0]  arb_gnt,
    input  logic          fifo_pop,
    output logic [IW-1:0] out_id,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [CW-1:0] fifo_count,
    output logic          timeout_err,
    output logic [IW-1:0] timeout_ch,
    output logic          proto_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int IW1 = IW + 1;
    localparam int WW  = $clog2(TIMEOUT + 1);

    localparam logic [WW-1:0]  TMAX     = WW'(TIMEOUT);
    localparam logic [IW1-1:0] NWRAP    = IW1'(N);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  mem_q [DEPTH];
    logic [WW-1:0]  wait_q [N];
    logic [WW-1:0]  wait_d [N];
    logic [N-1:0]   pend_q, pend_d;
    logic           terr_q, terr_d;
    logic [IW-1:0]  tch_q, tch_d;
    logic           perr_q, perr_d;

    logic           pop_eff;
    logic           can_push;
    logic           gnt_valid;
    logic [IW-1:0]  gnt_idx;
    logic [IW1-1:0] cand;
    logic           to_hit;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign fifo_count  = count_q;
    assign out_id      = fifo_empty ? '0 : mem_q[rd_q];
    assign timeout_err = terr_q;
    assign timeout_ch  = tch_q;
    assign proto_err   = perr_q;

    // A full FIFO can still accept a grant when the head leaves on the same edge.
    assign pop_eff  = fifo_pop && !fifo_empty;
    assign can_push = !fifo_full || pop_eff;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (rst_n && can_push) begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr_q} + IW1'(k);
                if (cand >= NWRAP) begin
                    cand = cand - NWRAP;
                end
                if (!gnt_valid && arb_req[cand[IW-1:0]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand[IW-1:0];
                end
            end
        end
    end

    always_comb begin
        arb_gnt = '0;
        if (gnt_valid) begin
            arb_gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
            wr_d  = wr_q + AW'(1);
        end
        if (pop_eff) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({gnt_valid, pop_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Wait counters saturate so a long-starved requester keeps reporting the timeout level.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (arb_req[i] && !arb_gnt[i]) begin
                wait_d[i] = (wait_q[i] == TMAX) ? wait_q[i] : wait_q[i] + WW'(1);
            end else begin
                wait_d[i] = '0;
            end
        end
    end

    always_comb begin
        terr_d = terr_q;
        tch_d  = tch_q;
        to_hit = 1'b0;
        if (!terr_q) begin
            for (int i = 0; i < N; i++) begin
                if (!to_hit && wait_d[i] == TMAX) begin
                    to_hit = 1'b1;
                    terr_d = 1'b1;
                    tch_d  = IW'(i);
                end
            end
        end
        perr_d = perr_q | (|(pend_q & ~arb_req));
        pend_d = arb_req & ~arb_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            pend_q  <= '0;
            terr_q  <= 1'b0;
            tch_q   <= '0;
            perr_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            terr_q  <= terr_d;
            tch_q   <= tch_d;
            perr_q  <= perr_d;
            wait_q  <= wait_d;
        end
    end

    // Storage needs no reset; out_id is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (gnt_valid) begin
            mem_q[wr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_rr_arb_fifo.sv
// Randomized and directed bench for rr_arb_fifo, compared each cycle against a
// queue-based behavioural model of arbitration, grant FIFO and error flags.
module tb_rr_arb_fifo;

    localparam int N       = 4;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int IW      = $clog2(N);
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  arb_req;
    logic [N-1:0]  arb_gnt;
    logic          fifo_pop;
    logic [IW-1:0] out_id;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          timeout_err;
    logic [IW-1:0] timeout_ch;
    logic          proto_err;

    int errCount   = 0;
    int checkCount = 0;

    int mQ[$];
    int mPtr;
    int mWait[N];
    bit mPend[N];
    bit mTerr;
    int mTch;
    bit mPerr;

    int            expGi;
    logic [N-1:0]  expGnt;
    logic [IW-1:0] expOut;
    logic [CW-1:0] expCnt;
    logic [IW-1:0] expTch;

    rr_arb_fifo #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .arb_req(arb_req),
        .arb_gnt(arb_gnt),
        .fifo_pop(fifo_pop),
        .out_id(out_id),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .fifo_count(fifo_count),
        .timeout_err(timeout_err),
        .timeout_ch(timeout_ch),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mQ.delete();
        mPtr  = 0;
        mTerr = 0;
        mTch  = 0;
        mPerr = 0;
        for (int i = 0; i < N; i++) begin
            mWait[i] = 0;
            mPend[i] = 0;
        end
    endtask

    // Expected combinational outputs for the inputs currently applied.
    task automatic model_comb();
        bit canPush;
        canPush = (mQ.size() < DEPTH) || (fifo_pop && mQ.size() > 0);
        expGi = -1;
        if (rst_n && canPush) begin
            for (int k = 0; k < N; k++) begin
                if (expGi < 0 && arb_req[(mPtr + k) % N]) begin
                    expGi = (mPtr + k) % N;
                end
            end
        end
        expGnt = '0;
        if (expGi >= 0) expGnt[expGi] = 1'b1;
        expOut = (mQ.size() > 0) ? IW'(mQ[0]) : '0;
        expCnt = CW'(mQ.size());
        expTch = IW'(mTch);
    endtask

    task automatic model_commit();
        if (fifo_pop && mQ.size() > 0) void'(mQ.pop_front());
        if (expGi >= 0) begin
            mQ.push_back(expGi);
            mPtr = (expGi + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (arb_req[i] && !expGnt[i]) mWait[i] = (mWait[i] < TIMEOUT) ? mWait[i] + 1 : TIMEOUT;
            else mWait[i] = 0;
        end
        if (!mTerr) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (mWait[i] >= TIMEOUT) begin
                    mTerr = 1;
                    mTch  = i;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (mPend[i] && !arb_req[i]) mPerr = 1;
            mPend[i] = arb_req[i] && !expGnt[i];
        end
    endtask

    // Called just after a rising edge; leaves time at the following falling edge.
    task automatic drive(input logic [N-1:0] r, input logic p);
        arb_req  = r;
        fifo_pop = p;
        model_comb();
        @(negedge clk);
    endtask

    task automatic commit();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        arb_req  = '0;
        fifo_pop = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        arb_req  = '1;
        fifo_pop = 1'b1;
        @(negedge clk);
        checkCount++; if (arb_gnt !== '0) begin errCount++; $display("[TB] FAIL reset_gnt got %b want 0", arb_gnt); end
        checkCount++; if (out_id !== '0) begin errCount++; $display("[TB] FAIL reset_out_id got %0d want 0", out_id); end
        checkCount++; if (fifo_count !== '0) begin errCount++; $display("[TB] FAIL reset_count got %0d want 0", fifo_count); end
        checkCount++; if (fifo_empty !== 1'b1) begin errCount++; $display("[TB] FAIL reset_empty got %b want 1", fifo_empty); end
        checkCount++; if (fifo_full !== 1'b0) begin errCount++; $display("[TB] FAIL reset_full got %b want 0", fifo_full); end
        checkCount++; if (timeout_err !== 1'b0) begin errCount++; $display("[TB] FAIL reset_terr got %b want 0", timeout_err); end
        checkCount++; if (timeout_ch !== '0) begin errCount++; $display("[TB] FAIL reset_tch got %0d want 0", timeout_ch); end
        checkCount++; if (proto_err !== 1'b0) begin errCount++; $display("[TB] FAIL reset_perr got %b want 0", proto_err); end
        arb_req  = '0;
        fifo_pop = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rotation();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(4'b1111, 1'b1);
            checkCount++; if (arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL rotate_gnt cyc %0d got %b want %b", c, arb_gnt, expGnt); end
            checkCount++; if (out_id !== expOut) begin errCount++; $display("[TB] FAIL rotate_out_id cyc %0d got %0d want %0d", c, out_id, expOut); end
            checkCount++; if (fifo_count !== expCnt) begin errCount++; $display("[TB] FAIL rotate_count cyc %0d got %0d want %0d", c, fifo_count, expCnt); end
            commit();
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(4'b0001, 1'b0);
            checkCount++; if (arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL fill_gnt cyc %0d got %b want %b", c, arb_gnt, expGnt); end
            checkCount++; if (fifo_count !== expCnt) begin errCount++; $display("[TB] FAIL fill_count cyc %0d got %0d want %0d", c, fifo_count, expCnt); end
            checkCount++; if (fifo_full !== (mQ.size() == DEPTH)) begin errCount++; $display("[TB] FAIL fill_full cyc %0d got %b want %b", c, fifo_full, mQ.size() == DEPTH); end
            commit();
        end
        drive(4'b0001, 1'b1);
        checkCount++; if (arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL fullpushpop_gnt got %b want %b", arb_gnt, expGnt); end
        commit();
        drive(4'b0000, 1'b0);
        checkCount++; if (fifo_count !== expCnt) begin errCount++; $display("[TB] FAIL fullpushpop_count got %0d want %0d", fifo_count, expCnt); end
        checkCount++; if (fifo_full !== 1'b1) begin errCount++; $display("[TB] FAIL fullpushpop_full got %b want 1", fifo_full); end
        checkCount++; if (proto_err !== mPerr) begin errCount++; $display("[TB] FAIL fill_perr got %b want %b", proto_err, mPerr); end
        commit();
    endtask

    task automatic test_pop_empty();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(4'b0000, 1'b1);
            checkCount++; if (fifo_count !== expCnt) begin errCount++; $display("[TB] FAIL popempty_count cyc %0d got %0d want %0d", c, fifo_count, expCnt); end
            checkCount++; if (fifo_empty !== 1'b1) begin errCount++; $display("[TB] FAIL popempty_empty cyc %0d got %b want 1", c, fifo_empty); end
            checkCount++; if (out_id !== expOut) begin errCount++; $display("[TB] FAIL popempty_out_id cyc %0d got %0d want %0d", c, out_id, expOut); end
            checkCount++; if (proto_err !== mPerr || timeout_err !== mTerr) begin errCount++; $display("[TB] FAIL popempty_err got %b%b want %b%b", proto_err, timeout_err, mPerr, mTerr); end
            commit();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < DEPTH; c++) begin
            drive(4'b0001, 1'b0);
            commit();
        end
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            drive(4'b0110, 1'b0);
            checkCount++; if (timeout_err !== mTerr) begin errCount++; $display("[TB] FAIL timeout_err cyc %0d got %b want %b", c, timeout_err, mTerr); end
            checkCount++; if (timeout_ch !== expTch) begin errCount++; $display("[TB] FAIL timeout_ch cyc %0d got %0d want %0d", c, timeout_ch, expTch); end
            commit();
        end
        for (int c = 0; c < 6; c++) begin
            drive(4'b0110, 1'b1);
            checkCount++; if (arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL timeout_resume_gnt cyc %0d got %b want %b", c, arb_gnt, expGnt); end
            checkCount++; if (timeout_err !== 1'b1 || timeout_ch !== IW'(1)) begin errCount++; $display("[TB] FAIL timeout_sticky cyc %0d got %b/%0d want 1/1", c, timeout_err, timeout_ch); end
            commit();
        end
    endtask

    task automatic test_proto_and_async_reset();
        do_reset();
        for (int c = 0; c < DEPTH; c++) begin
            drive(4'b0001, 1'b0);
            commit();
        end
        drive(4'b0100, 1'b0);
        checkCount++; if (arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL proto_gnt got %b want %b", arb_gnt, expGnt); end
        commit();
        drive(4'b0000, 1'b0);
        checkCount++; if (proto_err !== mPerr) begin errCount++; $display("[TB] FAIL proto_before got %b want %b", proto_err, mPerr); end
        commit();
        drive(4'b0000, 1'b0);
        checkCount++; if (proto_err !== mPerr) begin errCount++; $display("[TB] FAIL proto_after got %b want %b", proto_err, mPerr); end
        // Drop reset away from any clock edge to observe the asynchronous clear.
        #2;
        arb_req = 4'b1111;
        rst_n   = 1'b0;
        #1;
        model_reset();
        checkCount++; if (arb_gnt !== '0) begin errCount++; $display("[TB] FAIL async_gnt got %b want 0", arb_gnt); end
        checkCount++; if (fifo_count !== '0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errCount++; $display("[TB] FAIL async_fifo got cnt %0d e %b f %b want 0 1 0", fifo_count, fifo_empty, fifo_full); end
        checkCount++; if (out_id !== '0) begin errCount++; $display("[TB] FAIL async_out_id got %0d want 0", out_id); end
        checkCount++; if (proto_err !== 1'b0 || timeout_err !== 1'b0) begin errCount++; $display("[TB] FAIL async_err got %b%b want 00", proto_err, timeout_err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0000, 1'b0);
        checkCount++; if (proto_err !== mPerr || arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL post_reset got perr %b gnt %b want %b %b", proto_err, arb_gnt, mPerr, expGnt); end
        commit();
    endtask

    task automatic test_random();
        logic [N-1:0]  r;
        logic [N-1:0]  lastGnt;
        logic [IW-1:0] dropIdx;
        do_reset();
        r       = '0;
        lastGnt = '0;
        for (int c = 0; c < 400; c++) begin
            r = (r & ~lastGnt) | N'($urandom & $urandom);
            if ($urandom_range(0, 31) == 0) begin
                dropIdx    = IW'($urandom_range(0, N - 1));
                r[dropIdx] = 1'b0;
            end
            drive(r, 1'($urandom_range(0, 1)));
            checkCount++; if (arb_gnt !== expGnt) begin errCount++; $display("[TB] FAIL rand_gnt cyc %0d got %b want %b", c, arb_gnt, expGnt); end
            checkCount++; if (out_id !== expOut) begin errCount++; $display("[TB] FAIL rand_out_id cyc %0d got %0d want %0d", c, out_id, expOut); end
            checkCount++; if (fifo_count !== expCnt) begin errCount++; $display("[TB] FAIL rand_count cyc %0d got %0d want %0d", c, fifo_count, expCnt); end
            checkCount++; if (fifo_empty !== (mQ.size() == 0) || fifo_full !== (mQ.size() == DEPTH)) begin errCount++; $display("[TB] FAIL rand_flags cyc %0d got e %b f %b size %0d", c, fifo_empty, fifo_full, mQ.size()); end
            checkCount++; if (timeout_err !== mTerr || timeout_ch !== expTch) begin errCount++; $display("[TB] FAIL rand_timeout cyc %0d got %b/%0d want %b/%0d", c, timeout_err, timeout_ch, mTerr, expTch); end
            checkCount++; if (proto_err !== mPerr) begin errCount++; $display("[TB] FAIL rand_perr cyc %0d got %b want %b", c, proto_err, mPerr); end
            lastGnt = expGnt;
            commit();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        arb_req  = '0;
        fifo_pop = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_fill();
        test_pop_empty();
        test_timeout();
        test_proto_and_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
